// File: rtl/pe_result_drain.sv
// Result drain for the 8x8 convolution PE array: waits out the array
// latency, snapshots the result bus, then streams results over valid/ready.
module pe_result_drain #(
    parameter int NUM_RES = 8,
    parameter int RES_W   = 9,
    parameter int LAT     = 2,
    localparam int IDX_W  = (NUM_RES > 1) ? $clog2(NUM_RES) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [NUM_RES*RES_W-1:0] conv_out,
    output logic                     busy,
    output logic [RES_W-1:0]         m_data,
    output logic [IDX_W-1:0]         m_idx,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic                     m_last,
    output logic                     done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [3:0]       WCNT_INIT = 4'(LAT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_RES - 1);

    state_t             state_q;
    logic [3:0]         wcnt_q;
    logic [IDX_W-1:0]   idx_q;
    logic [IDX_W-1:0]   idx_d;
    logic [RES_W-1:0]   cap_q [NUM_RES];
    logic [RES_W-1:0]   res_w [NUM_RES];
    logic [RES_W-1:0]   m_data_q;
    logic               busy_q;
    logic               m_valid_q;
    logic               m_last_q;
    logic               done_q;

    always_comb begin
        for (int k = 0; k < NUM_RES; k++) begin
            res_w[k] = conv_out[k*RES_W +: RES_W];
        end
    end

    assign idx_d = idx_q + 1'b1;

    // Outputs are registered so m_valid never depends combinationally on m_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            wcnt_q    <= '0;
            idx_q     <= '0;
            m_data_q  <= '0;
            busy_q    <= 1'b0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            done_q    <= 1'b0;
            for (int k = 0; k < NUM_RES; k++) begin
                cap_q[k] <= '0;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= WAIT;
                        wcnt_q  <= WCNT_INIT;
                        busy_q  <= 1'b1;
                    end
                end
                WAIT: begin
                    if (wcnt_q == '0) begin
                        for (int k = 0; k < NUM_RES; k++) begin
                            cap_q[k] <= res_w[k];
                        end
                        idx_q     <= '0;
                        m_data_q  <= res_w[0];
                        m_last_q  <= (LAST_IDX == '0);
                        m_valid_q <= 1'b1;
                        state_q   <= SEND;
                    end else begin
                        wcnt_q <= wcnt_q - 1'b1;
                    end
                end
                SEND: begin
                    if (m_ready) begin
                        if (idx_q == LAST_IDX) begin
                            m_valid_q <= 1'b0;
                            m_last_q  <= 1'b0;
                            done_q    <= 1'b1;
                            state_q   <= DONE;
                        end else begin
                            idx_q    <= idx_d;
                            m_data_q <= cap_q[idx_d];
                            m_last_q <= (idx_d == LAST_IDX);
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign m_data  = m_data_q;
    assign m_idx   = idx_q;
    assign m_valid = m_valid_q;
    assign m_last  = m_last_q;
    assign done    = done_q;

endmodule

// File: tb/tb_pe_result_drain.sv
// Bench for pe_result_drain: three latency variants driven in parallel and
// checked every cycle against a frame-level model, plus pinned literals.
module tb_pe_result_drain;

    localparam int N = 8;
    localparam int W = 9;
    localparam int LATS [3] = '{2, 1, 15};

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         rdy;
    logic [71:0]  conv;

    logic         busy_w [3];
    logic [8:0]   dat_w  [3];
    logic [2:0]   idx_w  [3];
    logic         val_w  [3];
    logic         last_w [3];
    logic         done_w [3];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    pe_result_drain #(.NUM_RES(8), .RES_W(9), .LAT(2)) u_l2 (
        .clk(clk), .rst(rst), .start(start), .conv_out(conv),
        .busy(busy_w[0]), .m_data(dat_w[0]), .m_idx(idx_w[0]),
        .m_valid(val_w[0]), .m_ready(rdy), .m_last(last_w[0]),
        .done(done_w[0])
    );

    pe_result_drain #(.NUM_RES(8), .RES_W(9), .LAT(1)) u_l1 (
        .clk(clk), .rst(rst), .start(start), .conv_out(conv),
        .busy(busy_w[1]), .m_data(dat_w[1]), .m_idx(idx_w[1]),
        .m_valid(val_w[1]), .m_ready(rdy), .m_last(last_w[1]),
        .done(done_w[1])
    );

    pe_result_drain #(.NUM_RES(8), .RES_W(9), .LAT(15)) u_l15 (
        .clk(clk), .rst(rst), .start(start), .conv_out(conv),
        .busy(busy_w[2]), .m_data(dat_w[2]), .m_idx(idx_w[2]),
        .m_valid(val_w[2]), .m_ready(rdy), .m_last(last_w[2]),
        .done(done_w[2])
    );

    task automatic chk(input string nm, input int g,
                       input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%0d exp=%0d t=%0t", nm, g, got, exp, $time);
        end
    endtask

    // Frame-level model: accepted start, cycles elapsed, results sent.
    bit         m_act [3];
    bit         m_snd [3];
    bit         m_dn  [3];
    int         m_t   [3];
    int         m_n   [3];
    logic [8:0] m_cap [3][8];

    always @(posedge clk or posedge rst) begin
        for (int g = 0; g < 3; g++) begin
            if (rst) begin
                m_act[g] = 0; m_snd[g] = 0; m_dn[g] = 0;
                m_t[g] = 0; m_n[g] = 0;
            end else if (!m_act[g]) begin
                if (start) begin
                    m_act[g] = 1; m_t[g] = 0; m_n[g] = 0;
                end
            end else if (m_dn[g]) begin
                m_act[g] = 0; m_dn[g] = 0;
            end else if (m_snd[g]) begin
                if (rdy) begin
                    m_n[g]++;
                    if (m_n[g] == N) begin
                        m_snd[g] = 0; m_dn[g] = 1;
                    end
                end
            end else begin
                m_t[g]++;
                if (m_t[g] == LATS[g]) begin
                    for (int k = 0; k < N; k++) m_cap[g][k] = conv[k*W +: W];
                    m_snd[g] = 1; m_n[g] = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int g = 0; g < 3; g++) begin
                chk("busy", g, busy_w[g], m_act[g]);
                chk("valid", g, val_w[g], m_snd[g]);
                chk("done", g, done_w[g], m_dn[g]);
                if (m_snd[g]) begin
                    chk("data", g, dat_w[g], m_cap[g][m_n[g]]);
                    chk("idx", g, idx_w[g], m_n[g]);
                    chk("last", g, last_w[g], m_n[g] == N - 1);
                end
            end
        end
    end

    // Handshake log, edge-numbered.
    int         xf [3];
    int         dc [3];
    int         fx [3];
    int         de [3][4];
    logic [8:0] dlog [3][64];

    always @(posedge clk) begin
        cyc++;
        if (!rst) begin
            for (int g = 0; g < 3; g++) begin
                if (val_w[g] && rdy) begin
                    if (xf[g] < 64) dlog[g][xf[g]] = dat_w[g];
                    if (fx[g] < 0) fx[g] = cyc;
                    xf[g]++;
                end
                if (done_w[g]) begin
                    if (dc[g] < 4) de[g][dc[g]] = cyc;
                    dc[g]++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_log();
        for (int g = 0; g < 3; g++) begin
            xf[g] = 0; dc[g] = 0; fx[g] = -1;
        end
    endtask

    task automatic set_pat(input int base);
        for (int i = 0; i < N; i++) conv[i*W +: W] = 9'(base + i);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        start = 1'b0;
        rdy = 1'b1;
        while ((busy_w[0] || busy_w[1] || busy_w[2]) && k < 300) begin
            step();
            k++;
        end
        chk("idle_timeout", 0, k < 300, 1);
    endtask

    task automatic run_frame(input bit bp, output int s);
        wait_idle();
        clr_log();
        set_pat(10);
        s = cyc + 1;
        for (int k = 0; k < 24; k++) begin
            start = (k == 0);
            rdy = (bp && k >= 3) ? (k % 2 == 0) : 1'b1;
            if (k == 3) conv = '1;
            step();
        end
        start = 1'b0;
        rdy = 1'b1;
        wait_idle();
    endtask

    int s;

    initial begin
        rst = 1'b1; start = 1'b0; rdy = 1'b0; conv = '0;
        clr_log();
        repeat (3) step();
        chk("rst_busy", 0, busy_w[0], 0);
        chk("rst_valid", 0, val_w[0], 0);
        chk("rst_last", 0, last_w[0], 0);
        chk("rst_done", 0, done_w[0], 0);
        chk("rst_data", 0, dat_w[0], 0);
        chk("rst_idx", 0, idx_w[0], 0);
        rst = 1'b0;
        chk_en = 1'b1;
        step();

        // nominal frame with capture isolation
        run_frame(0, s);
        chk("nom_xfers", 0, xf[0], 8);
        for (int i = 0; i < N; i++) chk("nom_data", i, dlog[0][i], 10 + i);
        chk("nom_first", 0, fx[0] - s, 3);
        chk("nom_dones", 0, dc[0], 1);
        chk("nom_done_at", 0, de[0][0] - s, 11);

        // backpressure, alternating from 0
        run_frame(1, s);
        chk("bp_xfers", 0, xf[0], 8);
        for (int i = 0; i < N; i++) chk("bp_data", i, dlog[0][i], 10 + i);
        chk("bp_first", 0, fx[0] - s, 4);
        chk("bp_done_at", 0, de[0][0] - s, 19);

        // start while busy: WAIT, SEND, DONE, then first IDLE cycle
        wait_idle();
        clr_log();
        set_pat(10);
        s = cyc + 1;
        for (int k = 0; k < 32; k++) begin
            start = (k == 0 || k == 1 || k == 5 || k == 11 || k == 12);
            if (k == 3) set_pat(20);
            step();
        end
        wait_idle();
        chk("sb_xfers", 0, xf[0], 16);
        chk("sb_dones", 0, dc[0], 2);
        chk("sb_d0", 0, dlog[0][0], 10);
        chk("sb_d7", 0, dlog[0][7], 17);
        chk("sb_d8", 0, dlog[0][8], 20);
        chk("sb_d15", 0, dlog[0][15], 27);
        chk("sb_done1", 0, de[0][0] - s, 11);
        chk("sb_done2", 0, de[0][1] - s, 23);

        // async reset after three transfers
        wait_idle();
        clr_log();
        set_pat(10);
        s = cyc + 1;
        for (int k = 0; k < 6; k++) begin
            start = (k == 0);
            step();
        end
        start = 1'b0;
        chk("ar_xfers", 0, xf[0], 3);
        #2 rst = 1'b1;
        #1;
        for (int g = 0; g < 3; g++) begin
            chk("ar_busy", g, busy_w[g], 0);
            chk("ar_valid", g, val_w[g], 0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) step();
        chk("ar_nodone", 0, dc[0], 0);
        run_frame(0, s);
        chk("ar2_xfers", 0, xf[0], 8);
        chk("ar2_d0", 0, dlog[0][0], 10);
        chk("ar2_d7", 0, dlog[0][7], 17);

        // latency corners: result k = 16*j + k in cycle j after start
        wait_idle();
        clr_log();
        s = cyc + 1;
        for (int k = 0; k < 26; k++) begin
            start = (k == 0);
            set_pat(k * 16);
            step();
        end
        wait_idle();
        chk("lat1_first", 1, fx[1] - s, 2);
        chk("lat15_first", 2, fx[2] - s, 16);
        chk("lat1_d0", 1, dlog[1][0], 16);
        chk("lat1_d7", 1, dlog[1][7], 23);
        chk("lat15_d0", 2, dlog[2][0], 240);
        chk("lat15_d7", 2, dlog[2][7], 247);
        chk("lat2_d0", 0, dlog[0][0], 32);
        chk("lat15_xfers", 2, xf[2], 8);

        // random traffic with occasional mid-cycle reset
        for (int k = 0; k < 3000; k++) begin
            start = ($urandom_range(0, 7) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            conv = {8'($urandom), $urandom, $urandom};
            step();
            if ($urandom_range(0, 499) == 0) begin
                #1 rst = 1'b1;
                #1 rst = 1'b0;
            end
        end
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
